// File: rtl/cla_serial_adder.sv
// Serial wide adder: streams one nibble per cycle through a single
// 4-bit carry-lookahead slice with a registered inter-nibble carry.

module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c4
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0]
         | (p[0] & cin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c4   = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
  end

endmodule

module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [3:0]       s_nib;
  logic             c4;
  logic [WIDTH-1:0] ps_shift;
  logic             last;

  cla u_cla (
    .a   (a_sh_q[3:0]),
    .b   (b_sh_q[3:0]),
    .cin (c_q),
    .s   (s_nib),
    .c4  (c4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      c_q     <= 1'b0;
      ps_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      c_q     <= c_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    last    = (cnt_q == LAST);
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slice result enters at the top so nibble 0 ends up at bit 0.
  always_comb begin
    ps_shift = ps_q >> 4;
    ps_shift[WIDTH-1 -: 4] = s_nib;
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    c_d    = c_q;
    ps_d   = ps_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = b;
          c_d    = cin;
          cnt_d  = '0;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 4;
        b_sh_d = b_sh_q >> 4;
        c_d    = c4;
        ps_d   = ps_shift;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          sum_d  = ps_shift;
          cout_d = c4;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard bench for cla_serial_adder: directed cases plus random
// operand pairs checked against plain integer addition.

module tb_cla_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] last_res = '0;
  logic       rst_prev = 1'b0;

  cla_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_prev <= rst;

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst_prev) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || {cout, sum} !== '0) begin
        bad++;
        $display("FAIL reset_vals busy=%b done=%b cout=%b sum=%h want 0",
                 busy, done, cout, sum);
      end
      last_res = '0;
    end else if (done === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done cout=%b sum=%h want no done",
                 cout, sum);
      end else begin
        e = exp_q.pop_front();
        if ({cout, sum} !== e) begin
          bad++;
          $display("FAIL result got cout=%b sum=%h want cout=%b sum=%h",
                   cout, sum, e[W], e[W-1:0]);
        end
        last_res = e;
      end
    end else begin
      total++;
      if ({cout, sum} !== last_res) begin
        bad++;
        $display("FAIL hold got cout=%b sum=%h want cout=%b sum=%h",
                 cout, sum, last_res[W], last_res[W-1:0]);
      end
    end
  end

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                       input logic tc, input bit mid);
    int lat;
    int bz;
    a     = ta;
    b     = tb2;
    cin   = tc;
    start = 1'b1;
    exp_q.push_back({1'b0, ta} + {1'b0, tb2} + {{W{1'b0}}, tc});
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    lat   = 0;
    bz    = 0;
    while (done !== 1'b1 && lat < 3 * NIB) begin
      if (busy === 1'b1) bz++;
      if (mid && lat == 1) begin
        start = 1'b1;
        a     = 16'hAAAA;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", lat, NIB);
    check("busy_cycles", bz, NIB);
    check("busy_low_at_done", int'(busy), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h1111;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    idle(2);
    check("no_op_after_reset", int'(busy), 0);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    idle(2);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    idle(1);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    idle(1);
    do_op(16'h0006, 16'h0003, 1'b0, 1'b1);
    idle(NIB + 2);
    do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    do_op(16'h1010, 16'h0101, 1'b1, 1'b0);
    idle(2);

    // Aborted run: reset lands on the second RUN edge.
    a     = 16'h8000;
    b     = 16'h8000;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    idle(NIB + 3);
    check("abort_no_done_pending", exp_q.size(), 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end

    idle(NIB + 3);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
